exception_sequencer: RTL
========================

Name: exception_sequencer

Overview:
- Multicycle FSM that sequences CPU exception entry: opcode-not-implemented (NOOP), arithmetic overflow (OVFL) and divide-by-zero (DIV0).
- Steers the memory-address source select onto the fixed cause-vector address and writes EPC.
- Waits out memory latency, then loads the PC with the zero-extended handler byte read from the vector.
- Sits beside the main control unit. The main controller stalls while exc_active is high.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from address-select valid to mem_rdata valid; legal range 1..15.
- EPC_OFFSET, 4, value subtracted from pc_in to form EPC (PC has already been incremented).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- exc_noop  in  1  NOOP event, sampled only in IDLE
- exc_ovfl  in  1  overflow event, sampled only in IDLE
- exc_div0  in  1  divide-by-zero event, sampled only in IDLE
- pc_in  in  32  current PC
- mem_rdata  in  32  memory read data
- src_add_mem  out  3  memory-address source select: 000 pc, 010 noop vector, 011 ovfl vector, 100 div0 vector
- epc_wr  out  1  EPC write strobe, one cycle
- epc_out  out  32  EPC write data
- pc_wr  out  1  PC write strobe, one cycle
- pc_out  out  32  PC write data
- exc_active  out  1  high whenever state is not IDLE
- exc_cause  out  2  latched cause: 00 none, 01 noop, 10 ovfl, 11 div0
- exc_done  out  1  one-cycle pulse at end of sequence

Behaviour:
- Reset (async, rst_n low): state=IDLE, src_add_mem=000, epc_wr=0, pc_wr=0, epc_out=0, pc_out=0, exc_cause=00, exc_done=0, wait counter=0.
- Releasing reset mid-sequence returns to IDLE. No partial EPC/PC write is repeated.
- All outputs are registered.
- States: IDLE -> SAVE_EPC -> WAIT -> LOAD_PC -> DONE -> IDLE.
- IDLE:
  - src_add_mem=000.
  - If any event is high, latch the cause and pc_in, then go to SAVE_EPC.
  - Priority when events coincide: noop > div0 > ovfl. Lower-priority events in the same cycle are discarded.
- SAVE_EPC (1 cycle):
  - epc_wr=1, epc_out = latched_pc - EPC_OFFSET (32-bit modular; pc 0 gives 0xFFFFFFFC).
  - src_add_mem = cause code (010/011/100).
  - Counter loads MEM_LAT.
- WAIT:
  - src_add_mem is held.
  - Counter decrements each cycle. Leave when it reaches 0 after MEM_LAT cycles in WAIT.
- LOAD_PC (1 cycle):
  - pc_wr=1, pc_out = {24'b0, mem_rdata[7:0]}.
  - src_add_mem is still held this cycle.
- DONE (1 cycle):
  - exc_done=1, src_add_mem=000.
  - exc_cause holds until the next exception is accepted.
- Latency: with the event sampled in IDLE at cycle N:
  - epc_wr is high at N+1.
  - pc_wr is high at N+2+MEM_LAT.
  - exc_done is high at N+3+MEM_LAT.
  - IDLE is reached at N+4+MEM_LAT; a new event may be accepted that cycle.
- Events while not in IDLE are ignored unless EXC_PEND_EN is defined.
- src_add_mem never takes values 001, 101, 110 or 111.

Optional Feature:
- Macro: EXC_PEND_EN.
- Defined:
  - A 3-bit pending register captures any event asserted while state is not IDLE, OR-accumulated.
  - In IDLE, pending bits are treated as asserted events, with the same priority.
  - The serviced bit is cleared on entry to SAVE_EPC. Other pending bits are kept.
  - Reset clears all pending bits.
- Undefined: no pending register; events outside IDLE are lost.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT -> all outputs 0 and src_add_mem=000 immediately (async); after release, state IDLE and no pc_wr.
- Single NOOP, MEM_LAT=1, pc_in=0x00000040, mem_rdata[7:0]=0xA5:
  - epc_wr at N+1 with epc_out=0x0000003C, src_add_mem=010.
  - pc_wr at N+3 with pc_out=0x000000A5.
  - exc_done at N+4; exc_cause=01.
- Simultaneous ovfl+div0 -> src_add_mem=100, exc_cause=11, ovfl dropped (macro off).
- MEM_LAT=3, overflow, pc_in=0 -> epc_out=0xFFFFFFFC; src_add_mem=011 held 5 cycles; pc_wr at N+5.
- Back-to-back: div0 asserted during WAIT of a noop sequence:
  - Macro off: ignored.
  - EXC_PEND_EN: second sequence starts exactly at IDLE after exc_done, with exc_cause=11.
- Idle check: no events for 100 cycles -> src_add_mem=000, exc_active=0, no strobes.

Source files
------------

// File: rtl/exception_sequencer_if.sv
// Exception sequencer bus bundle: event inputs, PC/memory data in, and the
// sequencer's select/strobe/data outputs.
//   master : core side (drives events, pc_in, mem_rdata; observes outputs)
//   slave  : exception_sequencer
interface exception_sequencer_if;
  logic        exc_noop;
  logic        exc_ovfl;
  logic        exc_div0;
  logic [31:0] pc_in;
  logic [31:0] mem_rdata;
  logic [2:0]  src_add_mem;
  logic        epc_wr;
  logic [31:0] epc_out;
  logic        pc_wr;
  logic [31:0] pc_out;
  logic        exc_active;
  logic [1:0]  exc_cause;
  logic        exc_done;

  modport master (
    output exc_noop, exc_ovfl, exc_div0, pc_in, mem_rdata,
    input  src_add_mem, epc_wr, epc_out, pc_wr, pc_out, exc_active, exc_cause, exc_done
  );

  modport slave (
    input  exc_noop, exc_ovfl, exc_div0, pc_in, mem_rdata,
    output src_add_mem, epc_wr, epc_out, pc_wr, pc_out, exc_active, exc_cause, exc_done
  );
endinterface

// File: rtl/exception_sequencer.sv
// Multicycle CPU exception-entry sequencer (NOOP / OVFL / DIV0).
// Steers the memory address select onto the cause vector, writes EPC, waits
// out memory latency, then loads PC with the zero-extended handler byte.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   excBus     : exception_sequencer_if.slave (events, pc_in, mem_rdata in;
//                src_add_mem, epc_wr/epc_out, pc_wr/pc_out, exc_active,
//                exc_cause, exc_done out; all outputs registered)
// Optional macro EXC_PEND_EN: remember events raised while busy and service
// them from IDLE with the same priority.
module exception_sequencer #(
  parameter int unsigned MEM_LAT    = 1,        // 1..15
  parameter logic [31:0] EPC_OFFSET = 32'd4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  exception_sequencer_if.slave  excBus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_SAVE_EPC, S_WAIT, S_LOAD_PC, S_DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   waitCnt;
  logic [2:0]         srcAddMem;
  logic               epcWr;
  logic [31:0]        epcOut;
  logic               pcWr;
  logic [31:0]        pcOut;
  logic               excActive;
  logic [1:0]         excCause;
  logic               excDone;

  // Raw events packed as {div0, ovfl, noop}
  logic [2:0] evtRaw;
  logic [2:0] evtEff;
  logic [1:0] selCause;

  assign evtRaw = {excBus.exc_div0, excBus.exc_ovfl, excBus.exc_noop};

  // Upper read-data bits are not part of the handler address
  logic unusedRdata;
  assign unusedRdata = ^excBus.mem_rdata[31:8];

`ifdef EXC_PEND_EN
  logic [2:0] pendQ;
  logic [2:0] servMask;

  assign evtEff = evtRaw | pendQ;

  // One-hot of the event being accepted this cycle (zero when none)
  always_comb begin
    servMask = 3'b000;
    unique case (selCause)
      2'b01:   servMask = 3'b001;
      2'b10:   servMask = 3'b010;
      2'b11:   servMask = 3'b100;
      default: servMask = 3'b000;
    endcase
  end

  // Accumulate events seen while busy; drop only the serviced one on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendQ <= 3'b000;
    end else if (state != S_IDLE) begin
      pendQ <= pendQ | evtRaw;
    end else begin
      pendQ <= pendQ & ~servMask;
    end
  end
`else
  assign evtEff = evtRaw;
`endif

  // Priority encode: noop > div0 > ovfl
  always_comb begin
    selCause = 2'b00;
    if (evtEff[0])      selCause = 2'b01;
    else if (evtEff[2]) selCause = 2'b11;
    else if (evtEff[1]) selCause = 2'b10;
  end

  // Cause code to vector-address select
  function automatic logic [2:0] causeToSrc(input logic [1:0] cause);
    unique case (cause)
      2'b01:   causeToSrc = 3'b010;
      2'b10:   causeToSrc = 3'b011;
      2'b11:   causeToSrc = 3'b100;
      default: causeToSrc = 3'b000;
    endcase
  endfunction

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      waitCnt   <= '0;
      srcAddMem <= 3'b000;
      epcWr     <= 1'b0;
      epcOut    <= '0;
      pcWr      <= 1'b0;
      pcOut     <= '0;
      excActive <= 1'b0;
      excCause  <= 2'b00;
      excDone   <= 1'b0;
    end else begin
      epcWr   <= 1'b0;
      pcWr    <= 1'b0;
      excDone <= 1'b0;
      unique case (state)
        S_IDLE: begin
          srcAddMem <= 3'b000;
          if (selCause != 2'b00) begin
            // EPC is formed from pc_in captured at acceptance
            state     <= S_SAVE_EPC;
            excCause  <= selCause;
            srcAddMem <= causeToSrc(selCause);
            epcWr     <= 1'b1;
            epcOut    <= excBus.pc_in - EPC_OFFSET;
            excActive <= 1'b1;
          end
        end
        S_SAVE_EPC: begin
          state   <= S_WAIT;
          waitCnt <= CNT_W'(MEM_LAT);
        end
        S_WAIT: begin
          waitCnt <= waitCnt - CNT_W'(1);
          // Read data is valid in the last WAIT cycle; capture it into PC
          if (waitCnt <= CNT_W'(1)) begin
            state <= S_LOAD_PC;
            pcWr  <= 1'b1;
            pcOut <= {24'b0, excBus.mem_rdata[7:0]};
          end
        end
        S_LOAD_PC: begin
          state     <= S_DONE;
          excDone   <= 1'b1;
          srcAddMem <= 3'b000;
        end
        S_DONE: begin
          state     <= S_IDLE;
          excActive <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          srcAddMem <= 3'b000;
          excActive <= 1'b0;
        end
      endcase
    end
  end

  assign excBus.src_add_mem = srcAddMem;
  assign excBus.epc_wr      = epcWr;
  assign excBus.epc_out     = epcOut;
  assign excBus.pc_wr       = pcWr;
  assign excBus.pc_out      = pcOut;
  assign excBus.exc_active  = excActive;
  assign excBus.exc_cause   = excCause;
  assign excBus.exc_done    = excDone;

endmodule
